alu_exec_unit: RTL and testbench

- Execution stage directly downstream of the opcode decoder.
- Accepts a decoded 3-bit opcode (001..111; 000 means illegal/unmapped) plus two operands through a valid/ready handshake.
- Executes the operation and returns a registered result with carry, zero and error flags through a second valid/ready handshake.
- Logic ops complete in one cycle; multiply is a multi-cycle shift-add sequence.

---
 rtl/alu_exec_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution stage behind the opcode decoder.
// Accepts a decoded opcode plus two operands over a valid/ready handshake and
// returns a registered result with carry/zero/err flags over a second
// valid/ready handshake. Logic ops take one cycle; MUL is a WIDTH-step
// shift-add sequence.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - opcode/operands presented
//   in_ready  - unit can accept (IDLE only)
//   opcode    - 3-bit decoded opcode, 000 = illegal
//   a, b      - operands
//   out_valid - result held (DONE only)
//   out_ready - consumer takes the result
//   result    - operation result
//   carry     - carry / borrow / product overflow
//   zero      - result == 0
//   err       - illegal opcode was accepted
module alu_exec_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam logic [2:0] OpIll = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [WIDTH-1:0]     r_result, w_result_d;
  logic                 r_carry, w_carry_d;
  logic                 r_zero, w_zero_d;
  logic                 r_err, w_err_d;
  logic [2*WIDTH-1:0]   r_acc, w_acc_d;
  logic [2*WIDTH-1:0]   r_mcand, w_mcand_d;
  logic [WIDTH-1:0]     r_mplier, w_mplier_d;
  logic [CNT_W-1:0]     r_cnt, w_cnt_d;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [CNT_W-1:0]     w_shamt;
  logic [WIDTH-1:0]     w_shl;
  logic [WIDTH-1:0]     w_op_res;
  logic                 w_op_carry;
  logic                 w_op_err;
  logic [2*WIDTH-1:0]   w_acc_step;

  assign w_sum   = {1'b0, a} + {1'b0, b};
  // The extra MSB of the widened difference is the unsigned borrow.
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_shamt = b[CNT_W-1:0];
  assign w_shl   = (w_shamt >= WidthCnt) ? '0 : (a << w_shamt);

  always_comb begin
    w_op_res   = '0;
    w_op_carry = 1'b0;
    w_op_err   = 1'b0;
    unique case (opcode)
      OpAdd: begin
        w_op_res   = w_sum[WIDTH-1:0];
        w_op_carry = w_sum[WIDTH];
      end
      OpSub: begin
        w_op_res   = w_diff[WIDTH-1:0];
        w_op_carry = w_diff[WIDTH];
      end
      OpAnd:   w_op_res = a & b;
      OpOr:    w_op_res = a | b;
      OpXor:   w_op_res = a ^ b;
      OpShl:   w_op_res = w_shl;
      OpIll:   w_op_err = 1'b1;
      default: w_op_res = '0;  // OpMul is handled by the sequencer
    endcase
  end

  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_state_d  = r_state;
    w_result_d = r_result;
    w_carry_d  = r_carry;
    w_zero_d   = r_zero;
    w_err_d    = r_err;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_cnt_d    = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (opcode == OpMul) begin
            w_acc_d    = '0;
            w_mcand_d  = {{WIDTH{1'b0}}, a};
            w_mplier_d = b;
            w_cnt_d    = '0;
            w_state_d  = StMul;
          end else begin
            w_result_d = w_op_res;
            w_carry_d  = w_op_carry;
            w_zero_d   = (w_op_res == '0);
            w_err_d    = w_op_err;
            w_state_d  = StDone;
          end
        end
      end
      StMul: begin
        // Multiplicand is pre-shifted each step so it always sits at the
        // weight of the multiplier bit currently in the LSB.
        w_acc_d    = w_acc_step;
        w_mcand_d  = r_mcand << 1;
        w_mplier_d = r_mplier >> 1;
        w_cnt_d    = r_cnt + CNT_W'(1);
        if (r_cnt == LastStep) begin
          w_result_d = w_acc_step[WIDTH-1:0];
          w_carry_d  = |w_acc_step[2*WIDTH-1:WIDTH];
          w_zero_d   = (w_acc_step[WIDTH-1:0] == '0);
          w_err_d    = 1'b0;
          w_state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_result <= w_result_d;
      r_carry  <= w_carry_d;
      r_zero   <= w_zero_d;
      r_err    <= w_err_d;
      r_acc    <= w_acc_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=8).
module tb_alu_exec_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       err;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one transaction; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
    in_valid = 1'b1;
    opcode   = op;
    a        = va;
    b        = vb;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input logic [7:0] er, input logic ec,
                        input logic ez, input logic ee, input int lat);
    int   n;
    logic rdy_seen;
    out_ready = 1'b1;
    issue(op, va, vb);
    n        = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      n++;
    end
    check({tag, ".latency"}, n, lat);
    check({tag, ".busy_ready"}, {31'd0, rdy_seen | in_ready}, 0);
    check({tag, ".result"}, {24'd0, result}, {24'd0, er});
    check({tag, ".carry"}, {31'd0, carry}, {31'd0, ec});
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    check({tag, ".err"}, {31'd0, err}, {31'd0, ee});
    tick();
    check({tag, ".vld_drop"}, {31'd0, out_valid}, 0);
    check({tag, ".rdy_back"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    logic saw;
    rst       = 1'b1;
    in_valid  = 1'b0;
    opcode    = 3'b000;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst.in_ready", {31'd0, in_ready}, 1);
    check("rst.out_valid", {31'd0, out_valid}, 0);
    check("rst.result", {24'd0, result}, 0);
    check("rst.flags", {29'd0, carry, zero, err}, 0);

    run_op("add", 3'b001, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1);
    run_op("sub_borrow", 3'b010, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 1);
    run_op("sub_eq", 3'b010, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    run_op("and", 3'b011, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0, 1'b0, 1);
    run_op("shl1", 3'b110, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1);
    run_op("shl8", 3'b110, 8'hFF, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    run_op("mul13x11", 3'b111, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 1'b0, 9);
    run_op("mul20x20", 3'b111, 8'd20, 8'd20, 8'h90, 1'b1, 1'b0, 1'b0, 9);
    run_op("mul_b0", 3'b111, 8'd77, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 9);

    // Back-pressure: result must stay frozen while inputs wiggle.
    out_ready = 1'b0;
    issue(3'b101, 8'hAA, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", {31'd0, out_valid}, 1);
      check("bp.in_ready", {31'd0, in_ready}, 0);
      check("bp.result", {24'd0, result}, 32'h55);
      in_valid = 1'b1;
      opcode   = 3'b001;
      a        = 8'h11 + 8'(i);
      b        = 8'h22;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp.result_last", {24'd0, result}, 32'h55);
    tick();
    check("bp.release_vld", {31'd0, out_valid}, 0);
    check("bp.release_rdy", {31'd0, in_ready}, 1);
    check("bp.result_kept", {24'd0, result}, 32'h55);

    run_op("illegal", 3'b000, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 1);
    run_op("or", 3'b100, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 1);

    // Reset in the middle of a multiply; the product must never surface.
    out_ready = 1'b1;
    issue(3'b111, 8'd200, 8'd3);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.in_ready", {31'd0, in_ready}, 1);
    check("mrst.out_valid", {31'd0, out_valid}, 0);
    check("mrst.result", {24'd0, result}, 0);
    check("mrst.flags", {29'd0, carry, zero, err}, 0);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) saw = 1'b1;
      tick();
    end
    check("mrst.no_stale", {31'd0, saw}, 0);
    run_op("add_after_rst", 3'b001, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
